// File: rtl/genie_text_loader.sv
// Game Genie text loader: turns a stream of ASCII Game Genie codes into strobed 38-bit
// code-table words, and keeps saturating counts of accepted and rejected codes.
package genie_text_loader_pkg;

  typedef struct packed {
    logic        strobe;
    logic [3:0]  index;
    logic        enable;
    logic        cmp_en;
    logic [14:0] addr;
    logic [7:0]  compare;
    logic [7:0]  replace;
  } gg_code_t;

  localparam int unsigned CODE_W = $bits(gg_code_t);

endpackage

module genie_text_loader
  import genie_text_loader_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_wr,
  input  logic [7:0]        in_data,
  input  logic              in_end,
  output logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  codes_loaded,
  output logic [CNT_W-1:0]  bad_codes
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NIB_N   = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned INDEX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_SKIP
  } state_t;

  state_t                      state, state_n;
  logic [LEN_W-1:0]            len, len_n;
  logic [NIB_N-1:0][NIB_W-1:0] nib, nib_n;
  gg_code_t                    code_q, code_n;
  logic                        emit, bad, eight;
  logic [NIB_W:0]              letter;
  logic                        is_letter, is_term;
  logic [NIB_W-1:0]            last;

  // Returns {valid, nibble} for a case-insensitive Game Genie letter.
  function automatic logic [NIB_W:0] letter_val(input logic [7:0] ch);
    case (ch)
      "A", "a": return {1'b1, 4'd0};
      "P", "p": return {1'b1, 4'd1};
      "Z", "z": return {1'b1, 4'd2};
      "L", "l": return {1'b1, 4'd3};
      "G", "g": return {1'b1, 4'd4};
      "I", "i": return {1'b1, 4'd5};
      "T", "t": return {1'b1, 4'd6};
      "Y", "y": return {1'b1, 4'd7};
      "E", "e": return {1'b1, 4'd8};
      "O", "o": return {1'b1, 4'd9};
      "X", "x": return {1'b1, 4'd10};
      "U", "u": return {1'b1, 4'd11};
      "K", "k": return {1'b1, 4'd12};
      "S", "s": return {1'b1, 4'd13};
      "V", "v": return {1'b1, 4'd14};
      "N", "n": return {1'b1, 4'd15};
      default:  return {1'b0, 4'd0};
    endcase
  endfunction

  assign letter    = letter_val(in_data);
  assign is_letter = letter[NIB_W];
  assign is_term   = (in_data == 8'h0A) || (in_data == 8'h0D) || (in_data == 8'h20) ||
                     (in_data == 8'h2B) || (in_data == 8'h2C);

  // Next state: the byte is applied first, then in_end acts on the resulting state.
  always_comb begin
    state_n = state;
    len_n   = len;
    nib_n   = nib;
    emit    = 1'b0;
    bad     = 1'b0;
    eight   = 1'b0;
    if (in_wr) begin
      case (state)
        S_IDLE: begin
          if (is_letter) begin
            nib_n[0] = letter[NIB_W-1:0];
            len_n    = LEN_W'(1);
            state_n  = S_COLLECT;
          end else if (!is_term) begin
            bad     = 1'b1;
            state_n = S_SKIP;
          end
        end
        S_COLLECT: begin
          if (is_letter && len != LEN_W'(NIB_N)) begin
            nib_n[len[2:0]] = letter[NIB_W-1:0];
            len_n           = len + LEN_W'(1);
          end else if (is_term) begin
            emit    = (len == LEN_W'(6)) || (len == LEN_W'(8));
            bad     = !emit;
            eight   = (len == LEN_W'(8));
            len_n   = '0;
            state_n = S_IDLE;
          end else begin
            bad     = 1'b1;
            len_n   = '0;
            state_n = S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_term) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (in_end) begin
      if (state_n == S_COLLECT) begin
        emit  = (len_n == LEN_W'(6)) || (len_n == LEN_W'(8));
        bad   = !emit;
        eight = (len_n == LEN_W'(8));
        len_n = '0;
      end
      state_n = S_IDLE;
    end
  end

  // Scrambled-nibble decode; address bit 15 is implied and not carried.
  always_comb begin
    last           = eight ? nib_n[7] : nib_n[5];
    code_n         = '0;
    code_n.strobe  = 1'b1;
    code_n.index   = INDEX_W'(codes_loaded);
    code_n.enable  = 1'b1;
    code_n.cmp_en  = eight;
    code_n.addr    = {nib_n[3][2:0], nib_n[4][3], nib_n[5][2:0], nib_n[1][3],
                      nib_n[2][2:0], nib_n[3][3], nib_n[4][2:0]};
    code_n.replace = {nib_n[0][3], nib_n[1][2:0], last[3], nib_n[0][2:0]};
    if (eight) code_n.compare = {nib_n[6][3], nib_n[7][2:0], nib_n[5][3], nib_n[6][2:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      len          <= '0;
      nib          <= '0;
      code_q       <= '0;
      codes_loaded <= '0;
      bad_codes    <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      nib   <= nib_n;
      if (emit) begin
        code_q <= code_n;
        if (codes_loaded != '1) codes_loaded <= codes_loaded + CNT_W'(1);
      end else begin
        code_q.strobe <= 1'b0;
      end
      if (bad && bad_codes != '1) bad_codes <= bad_codes + CNT_W'(1);
    end
  end

  assign code = code_q;

endmodule
